// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment display driver.
//   SEG7_NUM_DIGITS : number of multiplexed digits on the display
//   SEG7_BLANK      : segment pattern with every segment off (active-low)
//   SEG7_TABLE      : active-low {g,f,e,d,c,b,a} patterns for hex 0-F
//   seg7_t          : one digit's segment vector
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int    SEG7_NUM_DIGITS = 4;
    localparam seg7_t SEG7_BLANK      = 7'h7F;

    // Index 0 is the first element. Letters render as A b C d E F.
    localparam seg7_t SEG7_TABLE [16] = '{
        7'h40, // 0
        7'h79, // 1
        7'h24, // 2
        7'h30, // 3
        7'h19, // 4
        7'h12, // 5
        7'h02, // 6
        7'h78, // 7
        7'h00, // 8
        7'h10, // 9
        7'h08, // A
        7'h03, // b
        7'h46, // C
        7'h21, // d
        7'h06, // E
        7'h0E  // F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to active-low seven-segment decoder.
// Ports:
//   nibble_i : 4-bit hex value
//   seg_o    : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG7_TABLE[nibble_i];

endmodule

// File: rtl/seg7_display_driver.sv
// ---------------------------------------------------------------------------
// seg7_display_driver
// Latches a 16-bit word and time-multiplexes it as four hex digits onto a
// common-anode four-digit seven-segment display. All display outputs come
// straight from flops and are active-low.
//
// Parameter:
//   REFRESH_DIV : clk cycles each digit stays lit (>= 1)
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   data       : word to display; digit k shows data[4k+3:4k]
//   load       : capture strobe for data into the shadow register
//   dp_en      : per-digit decimal point enable, active-high, used live
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   an         : digit anodes, active-low, one-hot-low while scanning
//   digit_tick : one-cycle pulse when an first shows a new digit
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN : blank digits 3..1 while that nibble and all
//                                higher nibbles are zero (digit 0 always lit)
// ---------------------------------------------------------------------------
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic        load,
    input  logic [3:0]  dp_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        digit_tick
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    // State
    logic [15:0]                shadow_q,    shadow_d;
    logic [CNT_W-1:0]           div_cnt_q,   div_cnt_d;
    logic [1:0]                 digit_idx_q, digit_idx_d;
    logic                       adv_q,       adv_d;
    logic [SEG7_NUM_DIGITS-1:0] an_q,        an_d;
    seg7_t                      seg_q,       seg_d;
    logic                       dp_q,        dp_d;
    logic                       tick_q,      tick_d;

    logic [3:0]                 nibble;
    seg7_t                      dec_seg;
    logic [SEG7_NUM_DIGITS-1:0] blank;

    hex_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // Leading-zero blank mask, derived from the shadow word so it lines up
    // with the nibble feeding the decoder in the same cycle.
    always_comb begin
        blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank[3] = (shadow_q[15:12] == 4'h0);
        blank[2] = blank[3] && (shadow_q[11:8] == 4'h0);
        blank[1] = blank[2] && (shadow_q[7:4]  == 4'h0);
        blank[0] = 1'b0;
`endif
    end

    always_comb begin
        shadow_d    = load ? data : shadow_q;

        div_cnt_d   = div_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        adv_d       = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + 2'd1;
            adv_d       = 1'b1;
        end

        nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];
        an_d   = ~(SEG7_NUM_DIGITS'(1) << digit_idx_q);
        seg_d  = blank[digit_idx_q] ? SEG7_BLANK : dec_seg;
        dp_d   = ~dp_en[digit_idx_q];
        // digit_idx moved at the previous edge; an shows it at this edge,
        // so the tick is delayed by one cycle to coincide with it.
        tick_d = adv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            adv_q       <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG7_BLANK;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            adv_q       <= adv_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_tick = tick_q;

endmodule
